button_event_ctrl: RTL

Input-side controller for the four player buttons. It synchronizes and debounces the red, blue, green and yellow buttons, and arbitrates simultaneous presses. Accepted presses are queued in a small FIFO behind a post-press lockout window. The CPU drains the FIFO one event per `poll_button` strobe, replacing the free-running re-read delay of the simple button latch with an explicit event queue.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/button_event_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the button event controller: colour codes, read-word
// bit positions and the lockout FSM state encoding.
package btn_pkg;

    localparam logic [1:0] BTN_RED    = 2'b00;
    localparam logic [1:0] BTN_BLUE   = 2'b01;
    localparam logic [1:0] BTN_GREEN  = 2'b10;
    localparam logic [1:0] BTN_YELLOW = 2'b11;

    localparam int unsigned RW_VALID    = 0;
    localparam int unsigned RW_COLOR_LO = 1;
    localparam int unsigned RW_COLOR_HI = 2;
    localparam int unsigned RW_OVF      = 3;

    typedef enum logic {
        LK_IDLE    = 1'b0,
        LK_LOCKOUT = 1'b1
    } lock_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, consecutive-cycle debounce counter
// and a single-cycle pulse on each 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level flips on the edge that completes the Nth disagreeing cycle.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = stable_q & ~prev_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Four-button input controller: debounce, fixed-priority arbitration, post-press
// lockout and an event FIFO drained by poll_button. Optional BTN_OVERFLOW_FLAG_EN.
module button_event_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LOCKOUT_CYCLES  = 25000000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    input  logic        poll_button,
    output logic [31:0] button_out,
    output logic        pending
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [LW-1:0] LK_LOAD    = LW'(LOCKOUT_CYCLES - 1);

    logic [3:0] raw;
    logic [3:0] press;

    assign raw = {yellow_button, green_button, blue_button, red_button};

    // Channel index equals the colour code.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock  (clock),
                .resetn (resetn),
                .raw_i  (raw[gi]),
                .press_o(press[gi])
            );
        end
    endgenerate

    logic       any_press;
    logic [1:0] sel_color;

    always_comb begin
        any_press = |press;
        sel_color = BTN_YELLOW;
        if (press[2]) sel_color = BTN_GREEN;
        if (press[1]) sel_color = BTN_BLUE;
        if (press[0]) sel_color = BTN_RED;
    end

    lock_state_e   state_q, state_d;
    logic [LW-1:0] lk_cnt_q, lk_cnt_d;
    logic          push_req;

    always_comb begin
        state_d  = state_q;
        lk_cnt_d = lk_cnt_q;
        push_req = 1'b0;
        case (state_q)
            LK_IDLE: begin
                if (any_press) begin
                    push_req = 1'b1;
                    lk_cnt_d = LK_LOAD;
                    state_d  = LK_LOCKOUT;
                end
            end
            LK_LOCKOUT: begin
                if (lk_cnt_q == '0) begin
                    state_d = LK_IDLE;
                end else begin
                    lk_cnt_d = lk_cnt_q - LW'(1);
                end
            end
            default: state_d = LK_IDLE;
        endcase
    end

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q, count_d;
    logic          full, pop, push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full    = (count_q == FULL_COUNT);
        pop     = poll_button && (count_q != '0);
        push    = push_req && (!full || pop);
        count_d = count_q;
        if (push && !pop) count_d = count_q + (PW+1)'(1);
        if (pop && !push) count_d = count_q - (PW+1)'(1);
    end

`ifdef BTN_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (pop) ovf_d = 1'b0;
        if (push_req && !push) ovf_d = 1'b1;
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= LK_IDLE;
            lk_cnt_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
`ifdef BTN_OVERFLOW_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lk_cnt_q <= lk_cnt_d;
            count_q  <= count_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
`ifdef BTN_OVERFLOW_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= sel_color;
    end

    always_comb begin
        button_out = 32'd0;
        if (pop) begin
            button_out[RW_VALID]                = 1'b1;
            button_out[RW_COLOR_HI:RW_COLOR_LO] = mem_q[rptr_q];
`ifdef BTN_OVERFLOW_FLAG_EN
            button_out[RW_OVF]                  = ovf_q;
`endif
        end
    end

    assign pending = (count_q != '0);

endmodule
